csr_file: RTL and testbench

Control/status register file for the LoongArch pipeline, responding to the CSR access, exception and ertn requests issued by the write-back stage. It holds the CRMD/PRMD/ECFG/ESTAT/ERA/BADV/EENTRY/SAVE0-3 registers and an optional countdown timer. It returns read data combinationally and updates state on the clock edge. It also produces the exception entry address, the return address and the interrupt-pending signal used for pipeline redirect.

---
 rtl/csr_file.sv | 183 ++++++++++++++++++
 tb/tb_csr_file.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// LoongArch CSR file: CRMD/PRMD/ECFG/ESTAT/ERA/BADV/EENTRY/SAVE0-3 with exception/ertn handling.
// Define CSR_TIMER_EN to build TID/TCFG/TVAL/TICLR and the ESTAT.IS[11] timer interrupt.
module csr_file #(
    parameter int PALEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    input  logic [31:0] coreid_in,
    output logic [31:0] csr_eentry,
    output logic [31:0] csr_era,
    output logic        has_int
);
    localparam logic [13:0] CsrCrmd   = 14'h0;
    localparam logic [13:0] CsrPrmd   = 14'h1;
    localparam logic [13:0] CsrEcfg   = 14'h4;
    localparam logic [13:0] CsrEstat  = 14'h5;
    localparam logic [13:0] CsrEra    = 14'h6;
    localparam logic [13:0] CsrBadv   = 14'h7;
    localparam logic [13:0] CsrEentry = 14'hc;
    localparam logic [13:0] CsrSave0  = 14'h30;
    localparam logic [13:0] CsrSave1  = 14'h31;
    localparam logic [13:0] CsrSave2  = 14'h32;
    localparam logic [13:0] CsrSave3  = 14'h33;
    localparam logic [13:0] CsrTid    = 14'h40;
    localparam logic [13:0] CsrTcfg   = 14'h41;
    localparam logic [13:0] CsrTval   = 14'h42;
    localparam logic [13:0] CsrTiclr  = 14'h44;

    logic [8:0]       r_crmd;
    logic [2:0]       r_prmd;
    logic [12:0]      r_ecfg;
    logic [1:0]       r_is_sw;
    logic [7:0]       r_is_hw;
    logic             r_is_ipi;
    logic [5:0]       r_ecode;
    logic [8:0]       r_esubcode;
    logic [PALEN-1:0] r_era;
    logic [PALEN-1:0] r_badv;
    logic [25:0]      r_eentry_va;
    logic [PALEN-1:0] r_save0, r_save1, r_save2, r_save3;

    logic        w_wen;
    logic        w_is_timer;
    logic [12:0] w_is;
    logic [31:0] w_estat;
    logic [31:0] w_rdata;
    logic [31:0] w_new;

    // csr_we loses to any same-cycle exception or ertn commit
    assign w_wen   = csr_we & ~wb_ex & ~ertn_flush;
    assign w_is    = {r_is_ipi, w_is_timer, 1'b0, r_is_hw, r_is_sw};
    assign w_estat = {1'b0, r_esubcode, r_ecode, 3'b0, w_is};
    assign w_new   = (w_rdata & ~csr_wmask) | (csr_wvalue & csr_wmask);

`ifdef CSR_TIMER_EN
    logic [31:0] r_tid, r_tcfg, r_tval;
    logic        r_is_timer;
    logic        w_tcfg_wr, w_ticlr_wr, w_fire, w_hold;

    assign w_tcfg_wr  = w_wen && (csr_num == CsrTcfg);
    assign w_ticlr_wr = w_wen && (csr_num == CsrTiclr) && w_new[0];
    assign w_fire     = r_tcfg[0] && (r_tval == 32'h0);
    // A one-shot timer parks at all-ones after firing
    assign w_hold     = (r_tval == 32'hffffffff) && !r_tcfg[1];
    assign w_is_timer = r_is_timer;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tid      <= coreid_in;
            r_tcfg     <= 32'h0;
            r_tval     <= 32'hffffffff;
            r_is_timer <= 1'b0;
        end else begin
            if (w_wen && (csr_num == CsrTid)) r_tid <= w_new;
            if (w_tcfg_wr) begin
                r_tcfg <= w_new;
                r_tval <= {w_new[31:2], 2'b0};
            end else if (w_fire) begin
                r_tval <= r_tcfg[1] ? {r_tcfg[31:2], 2'b0} : 32'hffffffff;
            end else if (r_tcfg[0] && !w_hold) begin
                r_tval <= r_tval - 32'd1;
            end
            if (w_fire && !w_tcfg_wr) r_is_timer <= 1'b1;
            else if (w_ticlr_wr)      r_is_timer <= 1'b0;
        end
    end
`else
    logic w_unused_coreid;
    assign w_unused_coreid = ^coreid_in;
    assign w_is_timer      = 1'b0;
`endif

    always_comb begin
        w_rdata = 32'h0;
        case (csr_num)
            CsrCrmd:   w_rdata = {23'h0, r_crmd};
            CsrPrmd:   w_rdata = {29'h0, r_prmd};
            CsrEcfg:   w_rdata = {19'h0, r_ecfg};
            CsrEstat:  w_rdata = w_estat;
            CsrEra:    w_rdata = r_era;
            CsrBadv:   w_rdata = r_badv;
            CsrEentry: w_rdata = {r_eentry_va, 6'h0};
            CsrSave0:  w_rdata = r_save0;
            CsrSave1:  w_rdata = r_save1;
            CsrSave2:  w_rdata = r_save2;
            CsrSave3:  w_rdata = r_save3;
`ifdef CSR_TIMER_EN
            CsrTid:    w_rdata = r_tid;
            CsrTcfg:   w_rdata = r_tcfg;
            CsrTval:   w_rdata = r_tval;
`endif
            default:   w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_crmd      <= 9'h8;
            r_prmd      <= 3'h0;
            r_ecfg      <= 13'h0;
            r_is_sw     <= 2'h0;
            r_is_hw     <= 8'h0;
            r_is_ipi    <= 1'b0;
            r_ecode     <= 6'h0;
            r_esubcode  <= 9'h0;
            r_era       <= '0;
            r_badv      <= '0;
            r_eentry_va <= 26'h0;
            r_save0     <= '0;
            r_save1     <= '0;
            r_save2     <= '0;
            r_save3     <= '0;
        end else begin
            r_is_hw  <= hw_int_in;
            r_is_ipi <= ipi_int_in;
            if (wb_ex) begin
                r_prmd      <= r_crmd[2:0];
                r_crmd[2:0] <= 3'h0;
                r_era       <= wb_pc;
                r_ecode     <= wb_ecode;
                r_esubcode  <= wb_esubcode;
                if (wb_ecode == 6'h8 || wb_ecode == 6'h9) r_badv <= wb_vaddr;
            end else if (ertn_flush) begin
                r_crmd[2:0] <= r_prmd;
            end else if (w_wen) begin
                case (csr_num)
                    CsrCrmd:   r_crmd      <= w_new[8:0];
                    CsrPrmd:   r_prmd      <= w_new[2:0];
                    CsrEcfg:   r_ecfg      <= w_new[12:0] & 13'h1bff;
                    CsrEstat:  r_is_sw     <= w_new[1:0];
                    CsrEra:    r_era       <= w_new;
                    CsrBadv:   r_badv      <= w_new;
                    CsrEentry: r_eentry_va <= w_new[31:6];
                    CsrSave0:  r_save0     <= w_new;
                    CsrSave1:  r_save1     <= w_new;
                    CsrSave2:  r_save2     <= w_new;
                    CsrSave3:  r_save3     <= w_new;
                    default:   ;
                endcase
            end
        end
    end

    assign csr_rvalue = csr_re ? w_rdata : 32'h0;
    assign csr_eentry = {r_eentry_va, 6'h0};
    assign csr_era    = r_era;
    assign has_int    = r_crmd[2] & |(w_is & r_ecfg);

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: a write/read vector table plus exception, interrupt and timer
// sequences; timer checks are built only when CSR_TIMER_EN is defined.
module tb_csr_file;
    logic        clk = 1'b0;
    logic        reset, csr_re, csr_we, wb_ex, ertn_flush, ipi_int_in;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue, csr_wmask, csr_wvalue, wb_pc, wb_vaddr, coreid_in;
    logic [31:0] csr_eentry, csr_era;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [7:0]  hw_int_in;
    logic        has_int;

    always #5 clk = ~clk;

    csr_file dut (
        .clk(clk), .reset(reset), .csr_re(csr_re), .csr_num(csr_num),
        .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .ertn_flush(ertn_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .coreid_in(coreid_in), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .has_int(has_int)
    );

    typedef struct {
        logic        we;
        logic [13:0] wnum;
        logic [31:0] wmask;
        logic [31:0] wval;
        logic [13:0] rnum;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
        csr_we = 1'b1; csr_num = n; csr_wmask = m; csr_wvalue = v;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [13:0] n, input logic [31:0] exp);
        csr_re = 1'b1; csr_num = n;
        #1;
        check(name, csr_rvalue, exp);
    endtask

    initial begin
        reset = 1'b1; csr_re = 1'b0; csr_we = 1'b0; csr_num = 14'h0;
        csr_wmask = 32'h0; csr_wvalue = 32'h0; wb_ex = 1'b0; wb_ecode = 6'h0;
        wb_esubcode = 9'h0; wb_pc = 32'h0; wb_vaddr = 32'h0; ertn_flush = 1'b0;
        hw_int_in = 8'h0; ipi_int_in = 1'b0; coreid_in = 32'h5;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        #1;
        check("rst_rvalue_re_low", csr_rvalue, 32'h0);
        check("rst_eentry", csr_eentry, 32'h0);
        check("rst_era", csr_era, 32'h0);
        check("rst_has_int", {31'h0, has_int}, 32'h0);

`ifdef CSR_TIMER_EN
        vecs.push_back('{1'b0, 14'h0,  32'h0,        32'h0,        14'h40, 32'h5});
        vecs.push_back('{1'b0, 14'h0,  32'h0,        32'h0,        14'h42, 32'hffffffff});
`endif
        vecs.push_back('{1'b0, 14'h0,  32'h0,        32'h0,        14'h0,  32'h8});
        vecs.push_back('{1'b0, 14'h0,  32'h0,        32'h0,        14'h7f, 32'h0});
        vecs.push_back('{1'b1, 14'hc,  32'hffffffff, 32'h1c008abc, 14'hc,  32'h1c008a80});
        vecs.push_back('{1'b1, 14'h0,  32'h0000000f, 32'hffffffff, 14'h0,  32'hf});
        vecs.push_back('{1'b1, 14'h0,  32'h00000001, 32'h0,        14'h0,  32'he});
        vecs.push_back('{1'b1, 14'h0,  32'hffffffff, 32'hffffffff, 14'h0,  32'h1ff});
        vecs.push_back('{1'b1, 14'h0,  32'hffffffff, 32'h0,        14'h0,  32'h0});
        vecs.push_back('{1'b1, 14'h1,  32'hffffffff, 32'hffffffff, 14'h1,  32'h7});
        vecs.push_back('{1'b1, 14'h4,  32'hffffffff, 32'hffffffff, 14'h4,  32'h1bff});
        vecs.push_back('{1'b1, 14'h4,  32'hffffffff, 32'h0,        14'h4,  32'h0});
        vecs.push_back('{1'b1, 14'h5,  32'hffffffff, 32'hffffffff, 14'h5,  32'h3});
        vecs.push_back('{1'b1, 14'h5,  32'hffffffff, 32'h0,        14'h5,  32'h0});
        vecs.push_back('{1'b1, 14'h32, 32'hffff0000, 32'h12345678, 14'h32, 32'h12340000});
        vecs.push_back('{1'b1, 14'h32, 32'h0000ffff, 32'h0000abcd, 14'h32, 32'h1234abcd});
        vecs.push_back('{1'b1, 14'h33, 32'hffffffff, 32'h5a5a5a5a, 14'h30, 32'h0});
        vecs.push_back('{1'b1, 14'h6,  32'hffffffff, 32'hdeadbeef, 14'h6,  32'hdeadbeef});
        vecs.push_back('{1'b1, 14'h7,  32'hffffffff, 32'h0badf00d, 14'h7,  32'h0badf00d});
        vecs.push_back('{1'b1, 14'h44, 32'hffffffff, 32'h1,        14'h44, 32'h0});
`ifdef CSR_TIMER_EN
        vecs.push_back('{1'b1, 14'h40, 32'hffffffff, 32'habcd0000, 14'h40, 32'habcd0000});
        vecs.push_back('{1'b1, 14'h42, 32'hffffffff, 32'h1234,     14'h42, 32'hffffffff});
`else
        vecs.push_back('{1'b1, 14'h40, 32'hffffffff, 32'h12345678, 14'h40, 32'h0});
        vecs.push_back('{1'b1, 14'h41, 32'hffffffff, 32'h0000000b, 14'h41, 32'h0});
        vecs.push_back('{1'b0, 14'h0,  32'h0,        32'h0,        14'h42, 32'h0});
`endif
        foreach (vecs[i]) begin
            if (vecs[i].we) wr(vecs[i].wnum, vecs[i].wmask, vecs[i].wval);
            rd_chk($sformatf("vec%0d", i), vecs[i].rnum, vecs[i].exp);
        end

        // Exception entry with ALE, then ertn
        wr(14'h0, 32'hffffffff, 32'h7);
        wb_ex = 1'b1; wb_ecode = 6'h9; wb_esubcode = 9'h3;
        wb_pc = 32'h1c000100; wb_vaddr = 32'h1234;
        tick();
        wb_ex = 1'b0;
        rd_chk("ex_crmd", 14'h0, 32'h0);
        rd_chk("ex_prmd", 14'h1, 32'h7);
        rd_chk("ex_era", 14'h6, 32'h1c000100);
        check("ex_era_port", csr_era, 32'h1c000100);
        rd_chk("ex_badv", 14'h7, 32'h1234);
        rd_chk("ex_estat", 14'h5, 32'h00c90000);
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        rd_chk("ertn_crmd", 14'h0, 32'h7);

        // Non-address exception together with a BADV write
        wb_ex = 1'b1; wb_ecode = 6'hb; wb_esubcode = 9'h0;
        wb_pc = 32'h1c000200; wb_vaddr = 32'h5555;
        csr_we = 1'b1; csr_num = 14'h7; csr_wmask = 32'hffffffff; csr_wvalue = 32'hffffffff;
        tick();
        wb_ex = 1'b0; csr_we = 1'b0;
        rd_chk("ex_we_badv", 14'h7, 32'h1234);
        rd_chk("ex_we_era", 14'h6, 32'h1c000200);
        rd_chk("ex_we_estat", 14'h5, 32'h000b0000);

        // ertn together with a SAVE0 write
        ertn_flush = 1'b1;
        csr_we = 1'b1; csr_num = 14'h30; csr_wmask = 32'hffffffff; csr_wvalue = 32'h99;
        tick();
        ertn_flush = 1'b0; csr_we = 1'b0;
        rd_chk("ertn_we_save0", 14'h30, 32'h0);
        rd_chk("ertn_we_crmd", 14'h0, 32'h7);
        csr_re = 1'b0; csr_num = 14'h0;
        #1 check("re_low_rvalue", csr_rvalue, 32'h0);

        // Hardware and IPI interrupts
        wr(14'h4, 32'hffffffff, 32'h4);
        wr(14'h0, 32'hffffffff, 32'h4);
        check("hwint_idle", {31'h0, has_int}, 32'h0);
        hw_int_in = 8'h01;
        #1 check("hwint_presample", {31'h0, has_int}, 32'h0);
        tick();
        check("hwint_set", {31'h0, has_int}, 32'h1);
        rd_chk("hwint_estat", 14'h5, 32'h000b0004);
        wr(14'h0, 32'h4, 32'h0);
        check("hwint_ie_off", {31'h0, has_int}, 32'h0);
        hw_int_in = 8'h00;
        wr(14'h4, 32'hffffffff, 32'h1000);
        wr(14'h0, 32'hffffffff, 32'h4);
        ipi_int_in = 1'b1;
        tick();
        check("ipi_set", {31'h0, has_int}, 32'h1);
        ipi_int_in = 1'b0;
        tick();
        check("ipi_clr", {31'h0, has_int}, 32'h0);

`ifdef CSR_TIMER_EN
        wr(14'h4, 32'hffffffff, 32'h800);
        wr(14'h41, 32'hffffffff, 32'hb);
        rd_chk("tm_load", 14'h42, 32'h8);
        for (int k = 1; k <= 8; k++) begin
            tick();
            rd_chk($sformatf("tm_cnt%0d", k), 14'h42, 32'(8 - k));
        end
        check("tm_prefire_int", {31'h0, has_int}, 32'h0);
        tick();
        rd_chk("tm_fire_estat", 14'h5, 32'h000b0800);
        check("tm_fire_int", {31'h0, has_int}, 32'h1);
        rd_chk("tm_reload", 14'h42, 32'h8);
        wr(14'h44, 32'hffffffff, 32'h1);
        check("tm_ticlr_int", {31'h0, has_int}, 32'h0);
        rd_chk("tm_after_clr", 14'h42, 32'h7);
        repeat (7) tick();
        rd_chk("tm_zero", 14'h42, 32'h0);
        wr(14'h44, 32'hffffffff, 32'h1);
        check("tm_fire_vs_clr", {31'h0, has_int}, 32'h1);
        rd_chk("tm_fire_vs_clr_tval", 14'h42, 32'h8);
        wr(14'h44, 32'hffffffff, 32'h1);
        wr(14'h41, 32'hffffffff, 32'h5);
        rd_chk("tm_os_load", 14'h42, 32'h4);
        repeat (4) tick();
        check("tm_os_prefire", {31'h0, has_int}, 32'h0);
        tick();
        check("tm_os_fire", {31'h0, has_int}, 32'h1);
        rd_chk("tm_os_park", 14'h42, 32'hffffffff);
        wr(14'h44, 32'hffffffff, 32'h1);
        tick();
        check("tm_os_nofire", {31'h0, has_int}, 32'h0);
        rd_chk("tm_os_hold", 14'h42, 32'hffffffff);
        wr(14'h41, 32'hffffffff, 32'hb);
        repeat (8) tick();
        wr(14'h41, 32'hffffffff, 32'h11);
        check("tm_tcfg_over_fire", {31'h0, has_int}, 32'h0);
        rd_chk("tm_tcfg_over_tval", 14'h42, 32'h10);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_chk("rst_mid_tval", 14'h42, 32'hffffffff);
        rd_chk("rst_mid_tcfg", 14'h41, 32'h0);
        rd_chk("rst_mid_tid", 14'h40, 32'h5);
`else
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif
        rd_chk("rst_mid_crmd", 14'h0, 32'h8);
        rd_chk("rst_mid_ecfg", 14'h4, 32'h0);
        check("rst_mid_era", csr_era, 32'h0);
        check("rst_mid_eentry", csr_eentry, 32'h0);
        check("rst_mid_has_int", {31'h0, has_int}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
